// File: rtl/inst_issue_queue.sv
// rtl/inst_issue_queue.sv - instruction FIFO feeding the add/sub/and pipeline
//
// Purpose: buffers 8-bit instructions {op,rs1,rs2,rd} and issues at most one
// per cycle on a registered inst port. A NOP bubble (8'h00) is issued whenever
// the queue is empty, held or flushed.
//
// Ports:
//   clk_i, rst_n_i     clock, asynchronous active-low reset
//   in_valid_i         push request
//   in_inst_i          instruction to push
//   in_ready_o         queue can accept this cycle (combinational)
//   hold_i             suppress issue this cycle
//   flush_i            synchronous discard of all queued entries
//   inst_o             registered instruction to pipeline
//   inst_valid_o       inst_o holds a dequeued entry (not a bubble)
//   count_o            entries currently stored, 0..DEPTH
//   full_o, empty_o    count_o == DEPTH / count_o == 0
//   issued_cnt_o       entries dequeued since reset, wrapping
module inst_issue_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             in_valid_i,
   input  logic [7:0]       in_inst_i,
   output logic             in_ready_o,
   input  logic             hold_i,
   input  logic             flush_i,
   output logic [7:0]       inst_o,
   output logic             inst_valid_o,
   output logic [AW:0]      count_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] issued_cnt_o
);

   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

   logic [7:0]       mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [7:0]       inst_q, inst_d;
   logic             inst_valid_q, inst_valid_d;
   logic [CNT_W-1:0] issued_q, issued_d;
   logic             push, pop;

   assign full_o       = (count_q == FULL_CNT);
   assign empty_o      = (count_q == '0);
   // Full blocks pushes even when a pop frees a slot in the same cycle.
   assign in_ready_o   = !full_o && !flush_i;
   assign push         = in_valid_i && in_ready_o;
   assign pop          = !empty_o && !hold_i && !flush_i;

   assign inst_o       = inst_q;
   assign inst_valid_o = inst_valid_q;
   assign count_o      = count_q;
   assign issued_cnt_o = issued_q;

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      inst_d       = 8'h00;
      inst_valid_d = 1'b0;
      issued_d     = issued_q;
      if (flush_i) begin
         // Drop everything; the issued total survives a flush.
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_d     = rd_ptr_q + PTR_ONE;
            inst_d       = mem_q[rd_ptr_q];
            inst_valid_d = 1'b1;
            issued_d     = issued_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         inst_q       <= 8'h00;
         inst_valid_q <= 1'b0;
         issued_q     <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         inst_q       <= inst_d;
         inst_valid_q <= inst_valid_d;
         issued_q     <= issued_d;
      end
   end

   // Storage is not reset; only the pointers define which entries are live.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_inst_i;
      end
   end

endmodule

// File: tb/tb_inst_issue_queue.sv
// tb/tb_inst_issue_queue.sv - self-checking bench for inst_issue_queue
module tb_inst_issue_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_inst = 8'h00;
   logic        in_ready;
   logic        hold = 1'b0;
   logic        flush = 1'b0;
   logic [7:0]  inst;
   logic        inst_valid;
   logic [2:0]  count;
   logic        full;
   logic        empty;
   logic [15:0] issued_cnt;

   int n_total = 0;
   int n_pass  = 0;
   bit chk_en  = 1'b0;

   // Behavioural model: a plain queue plus the last issued word.
   logic [7:0] m_q [$];
   logic [7:0] m_inst = 8'h00;
   logic       m_valid = 1'b0;
   int         m_issued = 0;

   inst_issue_queue #(.DEPTH(4), .AW(2), .CNT_W(16)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .in_valid_i   (in_valid),
      .in_inst_i    (in_inst),
      .in_ready_o   (in_ready),
      .hold_i       (hold),
      .flush_i      (flush),
      .inst_o       (inst),
      .inst_valid_o (inst_valid),
      .count_o      (count),
      .full_o       (full),
      .empty_o      (empty),
      .issued_cnt_o (issued_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
   endtask

   always @(negedge rst_n) begin
      m_q.delete();
      m_inst   = 8'h00;
      m_valid  = 1'b0;
      m_issued = 0;
   end

   always @(posedge clk) begin
      if (rst_n) begin
         bit m_ready, m_push, m_pop;
         m_ready = (m_q.size() < DEPTH) && !flush;
         m_push  = in_valid && m_ready;
         m_pop   = (m_q.size() > 0) && !hold && !flush;
         if (flush) begin
            m_q.delete();
            m_inst  = 8'h00;
            m_valid = 1'b0;
         end else begin
            if (m_pop) begin
               m_inst   = m_q.pop_front();
               m_valid  = 1'b1;
               m_issued = (m_issued + 1) % 65536;
            end else begin
               m_inst  = 8'h00;
               m_valid = 1'b0;
            end
            if (m_push) m_q.push_back(in_inst);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("inst",       32'(inst),       32'(m_inst));
         check("inst_valid", 32'(inst_valid), 32'(m_valid));
         check("count",      32'(count),      32'(m_q.size()));
         check("full",       32'(full),       32'(m_q.size() == DEPTH));
         check("empty",      32'(empty),      32'(m_q.size() == 0));
         check("in_ready",   32'(in_ready),   32'((m_q.size() < DEPTH) && !flush));
         check("issued_cnt", 32'(issued_cnt), 32'(m_issued));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   logic [7:0] vals [5];

   initial begin
      vals[0] = 8'h46; vals[1] = 8'h9B; vals[2] = 8'h00; vals[3] = 8'h5E; vals[4] = 8'hA1;

      // 1: reset then idle
      step(); step();
      rst_n = 1'b1;
      chk_en = 1'b1;
      step(); step(); step();
      check("t1_inst",  32'(inst), 32'h00);
      check("t1_valid", 32'(inst_valid), 32'h0);
      check("t1_empty", 32'(empty), 32'h1);
      check("t1_ready", 32'(in_ready), 32'h1);
      check("t1_count", 32'(count), 32'h0);

      // 2: single push, no bypass
      in_valid = 1'b1; in_inst = 8'h46;
      step();
      in_valid = 1'b0;
      check("t2_count1", 32'(count), 32'h1);
      check("t2_valid1", 32'(inst_valid), 32'h0);
      step();
      check("t2_inst",   32'(inst), 32'h46);
      check("t2_valid2", 32'(inst_valid), 32'h1);
      check("t2_count2", 32'(count), 32'h0);
      check("t2_issued", 32'(issued_cnt), 32'h1);

      // 3: hold while pushing five; fifth refused; release drains in order
      hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_inst = vals[i];
         #1;
         check("t3_ready", 32'(in_ready), (i < 4) ? 32'h1 : 32'h0);
         step();
      end
      in_valid = 1'b0;
      check("t3_full", 32'(full), 32'h1);
      hold = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("t3_order", 32'(inst), 32'(vals[i]));
         check("t3_valid", 32'(inst_valid), 32'h1);
      end
      step();
      check("t3_bubble", 32'(inst_valid), 32'h0);
      check("t3_issued", 32'(issued_cnt), 32'h5);

      // 4: full queue refuses a push even while popping
      hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_inst = 8'h10 + 8'(i);
         step();
      end
      hold = 1'b0; in_valid = 1'b1; in_inst = 8'hC7;
      #1;
      check("t4_ready_full", 32'(in_ready), 32'h0);
      step();
      check("t4_count_a", 32'(count), 32'h3);
      step();
      in_valid = 1'b0;
      check("t4_count_b", 32'(count), 32'h3);
      for (int i = 0; i < 5; i++) step();
      check("t4_issued", 32'(issued_cnt), 32'd10);
      check("t4_last", 32'(inst_valid), 32'h0);

      // 5: flush with a colliding push
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_inst = 8'h20 + 8'(i);
         step();
      end
      flush = 1'b1; in_valid = 1'b1; in_inst = 8'hFF;
      step();
      flush = 1'b0; in_valid = 1'b0; hold = 1'b0;
      check("t5_count",  32'(count), 32'h0);
      check("t5_inst",   32'(inst), 32'h00);
      check("t5_valid",  32'(inst_valid), 32'h0);
      check("t5_issued", 32'(issued_cnt), 32'd10);
      step();
      check("t5_absent", 32'(inst_valid), 32'h0);

      // 6a: asynchronous reset between edges while issuing
      in_valid = 1'b1; in_inst = 8'h33;
      step(); step(); step();
      rst_n = 1'b0;
      #1;
      check("t6_inst",   32'(inst), 32'h00);
      check("t6_valid",  32'(inst_valid), 32'h0);
      check("t6_count",  32'(count), 32'h0);
      check("t6_issued", 32'(issued_cnt), 32'h0);
      in_valid = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      check("t6_lost", 32'(inst_valid), 32'h0);

      // 6b: stream one entry per cycle until issued_cnt wraps
      in_valid = 1'b1;
      for (int i = 0; i < 65537; i++) begin
         in_inst = 8'(i);
         step();
         if (i == 65535) check("t6_near_wrap", 32'(issued_cnt), 32'hFFFF);
      end
      in_valid = 1'b0;
      check("t6_wrap",      32'(issued_cnt), 32'h0);
      check("t6_wrap_cnt",  32'(count), 32'h1);
      check("t6_wrap_inst", 32'(inst), 32'hFF);
      step(); step();

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
